pe_request_scanner: RTL and testbench

//  Downstream consumer of the 256-bit priority encoder stage: accepts a request vector, then

---
 rtl/pe_request_scanner_if.sv | 28 ++
 rtl/pe_request_scanner.sv | 88 ++++++++
 tb/tb_pe_request_scanner.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pe_request_scanner_if.sv
// Request-vector in / index-stream out handshake bundle for pe_request_scanner.
// The slave modport is the scanner; the master modport is the producer/consumer side.
interface pe_request_scanner_if #(
    parameter int WIDTH = 256,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [WIDTH-1:0] out_onehot;
    logic             out_last;
    logic             done;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_onehot, out_last, done, count
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_onehot, out_last, done, count
    );
endinterface

// File: rtl/pe_request_scanner.sv
// Serialises a captured request vector into a stream of set-bit indices, highest first,
// clearing each granted bit; pulses done when the vector is drained (or was empty).
module pe_request_scanner #(
    parameter int WIDTH = 256,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    pe_request_scanner_if.slave bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] top_idx;
    logic [WIDTH-1:0] top_onehot;
    logic             single;

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending_q[i]) top_idx = IDX_W'(i);
        end
    end

    always_comb begin
        top_onehot          = '0;
        top_onehot[top_idx] = 1'b1;
    end

    // x & (x-1) strips the lowest set bit; zero result means at most one bit remains.
    assign single = ((pending_q & (pending_q - WIDTH'(1))) == '0);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    pending_d = bus.in_vec;
                    count_d   = '0;
                    if (bus.in_vec != '0) state_d = SCAN;
                    else                  done_d  = 1'b1;
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    pending_d = pending_q & ~top_onehot;
                    count_d   = count_q + CNT_W'(1);
                    if (single) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

    // Stream outputs come straight from registered pending, so they hold under backpressure.
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == SCAN);
    assign bus.out_idx    = (state_q == SCAN) ? top_idx : '0;
    assign bus.out_onehot = (state_q == SCAN) ? top_onehot : '0;
    assign bus.out_last   = (state_q == SCAN) && single;
    assign bus.done       = done_q;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_pe_request_scanner.sv
// Directed bench for pe_request_scanner: hand-computed index streams, backpressure,
// empty / full / edge vectors, and reset abandoning a partial stream.
module tb_pe_request_scanner;
    localparam int WIDTH = 256;
    localparam int IDX_W = 8;
    localparam int CNT_W = 9;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pe_request_scanner_if #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    pe_request_scanner #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are all register-derived, so sample 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] vec);
        bus.in_valid = 1'b1;
        bus.in_vec   = vec;
        tick();
        bus.in_valid = 1'b0;
        bus.in_vec   = '0;
    endtask

    // Checks the full beat presentation for an expected index.
    task automatic chk_beat(input string tag, input int idx, input logic last, input int cnt);
        logic [WIDTH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        chk({tag, ".valid"},  bus.out_valid, 1'b1);
        chk({tag, ".idx"},    bus.out_idx, idx);
        chk({tag, ".onehot"}, bus.out_onehot, oh);
        chk({tag, ".last"},   bus.out_last, last);
        chk({tag, ".rdy"},    bus.in_ready, 1'b0);
        chk({tag, ".count"},  bus.count, cnt);
    endtask

    task automatic chk_idle(input string tag, input logic dn, input int cnt);
        chk({tag, ".valid"},  bus.out_valid, 1'b0);
        chk({tag, ".idx"},    bus.out_idx, '0);
        chk({tag, ".onehot"}, bus.out_onehot, '0);
        chk({tag, ".last"},   bus.out_last, 1'b0);
        chk({tag, ".rdy"},    bus.in_ready, 1'b1);
        chk({tag, ".done"},   bus.done, dn);
        chk({tag, ".count"},  bus.count, cnt);
    endtask

    initial begin
        int               seq [9];
        logic [WIDTH-1:0] edge_vec;
        seq = '{14, 12, 11, 9, 8, 7, 4, 1, 0};

        // Reset held for two cycles
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_vec   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk_idle("reset", 1'b0, 0);
        rst = 1'b0;
        tick();
        chk_idle("post_reset", 1'b0, 0);

        // Single bit 2
        bus.out_ready = 1'b1;
        send(256'd4);
        chk_beat("v4", 2, 1'b1, 0);
        tick();
        chk_idle("v4_done", 1'b1, 1);

        // Accept 9 in the same cycle the done pulse is high
        send(256'd9);
        chk_beat("v9_b0", 3, 1'b0, 0);
        chk("v9_b0.done", bus.done, 1'b0);
        tick();
        chk_beat("v9_b1", 0, 1'b1, 1);
        tick();
        chk_idle("v9_done", 1'b1, 2);
        tick();
        chk_idle("v9_after", 1'b0, 2);

        // 0x5B93 with out_ready alternating: outputs frozen on stalled cycles
        send(256'h5B93);
        for (int k = 0; k < 9; k++) begin
            chk_beat($sformatf("v5b93_b%0d", k), seq[k], logic'(k == 8), k);
            bus.out_ready = 1'b0;
            tick();
            chk_beat($sformatf("v5b93_hold%0d", k), seq[k], logic'(k == 8), k);
            bus.out_ready = 1'b1;
            tick();
        end
        chk_idle("v5b93_done", 1'b1, 9);

        // Empty vector: done without any beat
        send('0);
        chk_idle("v0_done", 1'b1, 0);
        tick();
        chk_idle("v0_after", 1'b0, 0);

        // All ones: 256 beats, count reaches WIDTH
        send('1);
        for (int k = WIDTH - 1; k >= 0; k--) begin
            chk("ones.idx", bus.out_idx, k);
            chk("ones.last", bus.out_last, logic'(k == 0));
            chk("ones.valid", bus.out_valid, 1'b1);
            tick();
        end
        chk_idle("ones_done", 1'b1, WIDTH);

        // Extreme bits only
        edge_vec          = '0;
        edge_vec[WIDTH-1] = 1'b1;
        edge_vec[0]       = 1'b1;
        send(edge_vec);
        chk_beat("edge_b0", 255, 1'b0, 0);
        tick();
        chk_beat("edge_b1", 0, 1'b1, 1);
        tick();
        chk_idle("edge_done", 1'b1, 2);

        // Reset after two beats abandons the stream without a done pulse
        send(256'h5B93);
        chk_beat("rst_b0", 14, 1'b0, 0);
        tick();
        chk_beat("rst_b1", 12, 1'b0, 1);
        tick();
        chk_beat("rst_b2", 11, 1'b0, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rst_mid", 1'b0, 0);
        tick();
        chk_idle("rst_after", 1'b0, 0);
        send(256'd1);
        chk_beat("v1", 0, 1'b1, 0);
        tick();
        chk_idle("v1_done", 1'b1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
